// File: rtl/sub_disp_pkg.sv
// Shared definitions for the subtractor result display.
//   - Segment constants (active-low, {g,f,e,d,c,b,a})
//   - 16-entry hex glyph table
//   - FSM state encoding
package sub_disp_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_MINUS = 7'h3F;

    // Index = hex value 0..F
    localparam logic [6:0] HEX_GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef enum logic {
        EMPTY = 1'b0,
        SHOW  = 1'b1
    } state_e;

endpackage

// File: rtl/hex_to_7seg.sv
// Hex digit to active-low 7-segment glyph, purely combinational.
// Ports:
//   hex_i  4-bit value 0..F
//   seg_o  segments {g,f,e,d,c,b,a}, active-low
module hex_to_7seg
    import sub_disp_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    assign seg_o = HEX_GLYPH[hex_i];

endmodule

// File: rtl/sub_result_display.sv
// Captures a 4-bit subtractor result on a load button edge, converts it to
// sign/magnitude and drives a 2-digit multiplexed active-low 7-segment display.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   S4..S1, Cout    difference bits (MSB..LSB) and carry-out (1 = no borrow)
//   load            raw push-button level, asynchronous to clk
//   seg             segments {g,f,e,d,c,b,a}, active-low
//   an              digit enables, active-low; bit0 magnitude, bit1 sign
//   valid/neg/zero  status flags for LEDs
module sub_result_display
    import sub_disp_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       S4,
    input  logic       S3,
    input  logic       S2,
    input  logic       S1,
    input  logic       Cout,
    input  logic       load,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       valid,
    output logic       neg,
    output logic       zero
);

    localparam int unsigned CntW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(REFRESH_DIV - 1);

    // Load synchronizer; ff1/ff2 resolve metastability, ff3 gives edge detect.
    logic ff1_q, ff2_q, ff3_q;
    logic pulse;

    logic [3:0]      mag_q, mag_d;
    logic            neg_q, neg_d;
    logic            zero_q, zero_d;
    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            digit_sel_q, digit_sel_d;
    logic [6:0]      glyph;

    assign pulse = ff2_q & ~ff3_q;

    always_comb begin
        logic [3:0] s;
        logic [3:0] m;
        s = {S4, S3, S2, S1};
        // Cout=0 means a borrow: S is the two's complement of a negative result.
        m = Cout ? s : (~s + 4'd1);

        mag_d   = mag_q;
        neg_d   = neg_q;
        zero_d  = zero_q;
        state_d = state_q;
        if (pulse) begin
            mag_d   = m;
            neg_d   = ~Cout;
            zero_d  = (m == 4'd0) & Cout;
            state_d = SHOW;
        end
    end

    always_comb begin
        cnt_d       = cnt_q + 1'b1;
        digit_sel_d = digit_sel_q;
        if (cnt_q == CntMax) begin
            cnt_d       = '0;
            digit_sel_d = ~digit_sel_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ff1_q       <= 1'b0;
            ff2_q       <= 1'b0;
            ff3_q       <= 1'b0;
            mag_q       <= 4'd0;
            neg_q       <= 1'b0;
            zero_q      <= 1'b0;
            state_q     <= EMPTY;
            cnt_q       <= '0;
            digit_sel_q <= 1'b0;
        end else begin
            ff1_q       <= load;
            ff2_q       <= ff1_q;
            ff3_q       <= ff2_q;
            mag_q       <= mag_d;
            neg_q       <= neg_d;
            zero_q      <= zero_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            digit_sel_q <= digit_sel_d;
        end
    end

    hex_to_7seg u_hex_to_7seg (
        .hex_i (mag_q),
        .seg_o (glyph)
    );

    always_comb begin
        an = digit_sel_q ? 2'b01 : 2'b10;
        if (state_q == EMPTY) begin
            seg = SEG_BLANK;
        end else if (!digit_sel_q) begin
            seg = glyph;
        end else begin
            seg = neg_q ? SEG_MINUS : SEG_BLANK;
        end
    end

    assign valid = (state_q == SHOW);
    assign neg   = neg_q;
    assign zero  = zero_q;

endmodule

// File: tb/tb_sub_result_display.sv
module tb_sub_result_display;

    logic       clk;
    logic       rst;
    logic       S4, S3, S2, S1;
    logic       Cout;
    logic       load;
    logic [6:0] seg;
    logic [1:0] an;
    logic       valid, neg, zero;

    int total = 0;
    int bad   = 0;

    sub_result_display #(
        .REFRESH_DIV (4)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .S4    (S4),
        .S3    (S3),
        .S2    (S2),
        .S1    (S1),
        .Cout  (Cout),
        .load  (load),
        .seg   (seg),
        .an    (an),
        .valid (valid),
        .neg   (neg),
        .zero  (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [3:0] s, input logic c);
        {S4, S3, S2, S1} = s;
        Cout = c;
    endtask

    // Wait (bounded) until the wanted digit is enabled, then check its glyph.
    task automatic chk_digit(input string tag, input logic [1:0] want_an,
                             input logic [6:0] exp_seg);
        int n;
        n = 0;
        while (an !== want_an && n < 10) begin
            tick();
            n++;
        end
        if (an !== want_an) chk({tag, "_an_timeout"}, 32'(an), 32'(want_an));
        chk(tag, 32'(seg), 32'(exp_seg));
    endtask

    // Rising edge on load, capture expected after the third edge.
    task automatic load_pulse(input string tag, input logic exp_valid_before);
        load = 1'b1;
        tick();
        tick();
        chk({tag, "_valid_k1"}, 32'(valid), 32'(exp_valid_before));
        tick();
        load = 1'b0;
    endtask

    task automatic chk_flags(input string tag, input logic v, input logic n, input logic z);
        chk({tag, "_valid"}, 32'(valid), 32'(v));
        chk({tag, "_neg"},   32'(neg),   32'(n));
        chk({tag, "_zero"},  32'(zero),  32'(z));
    endtask

    initial begin
        rst  = 1'b1;
        load = 1'b0;
        set_in(4'b0000, 1'b1);
        #1;
        chk("rst_an", 32'(an), 32'(2'b10));
        chk("rst_seg", 32'(seg), 32'h7F);
        chk_flags("rst", 1'b0, 1'b0, 1'b0);

        tick();
        tick();
        #3 rst = 1'b0;
        // After 5 edges the sign digit is enabled; reset mid-scan.
        repeat (5) tick();
        chk("scan_pre_rst", 32'(an), 32'(2'b01));
        #3 rst = 1'b1;
        #1;
        chk("midscan_rst_an", 32'(an), 32'(2'b10));
        chk("midscan_rst_seg", 32'(seg), 32'h7F);
        chk_flags("midscan_rst", 1'b0, 1'b0, 1'b0);

        @(posedge clk);
        #3 rst = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk($sformatf("scan_%0d", i), 32'(an), (i >= 4 && i < 8) ? 32'h1 : 32'h2);
            chk($sformatf("empty_seg_%0d", i), 32'(seg), 32'h7F);
        end

        // 7 - 3 = +4
        set_in(4'b0100, 1'b1);
        load_pulse("p7m3", 1'b0);
        chk_flags("p7m3", 1'b1, 1'b0, 1'b0);
        chk_digit("p7m3_d0", 2'b10, 7'h19);
        chk_digit("p7m3_d1", 2'b01, 7'h7F);
        tick();

        // 3 - 7 = -4
        set_in(4'b1100, 1'b0);
        load_pulse("p3m7", 1'b1);
        chk_flags("p3m7", 1'b1, 1'b1, 1'b0);
        chk_digit("p3m7_d0", 2'b10, 7'h19);
        chk_digit("p3m7_d1", 2'b01, 7'h3F);
        tick();

        // 9 - 9 = 0
        set_in(4'b0000, 1'b1);
        load_pulse("p9m9", 1'b1);
        chk_flags("p9m9", 1'b1, 1'b0, 1'b1);
        chk_digit("p9m9_d0", 2'b10, 7'h40);
        chk_digit("p9m9_d1", 2'b01, 7'h7F);
        tick();

        // 0 - 15 = -15
        set_in(4'b0001, 1'b0);
        load_pulse("p0m15", 1'b1);
        chk_flags("p0m15", 1'b1, 1'b1, 1'b0);
        chk_digit("p0m15_d0", 2'b10, 7'h0E);
        chk_digit("p0m15_d1", 2'b01, 7'h3F);
        tick();

        // S=0 with borrow: magnitude 0 but negative, so zero stays low
        set_in(4'b0000, 1'b0);
        load_pulse("neg0", 1'b1);
        chk_flags("neg0", 1'b1, 1'b1, 1'b0);
        chk_digit("neg0_d0", 2'b10, 7'h40);
        tick();

        // Hold load high, change inputs: no recapture
        set_in(4'b0100, 1'b1);
        load = 1'b1;
        repeat (3) tick();
        chk_flags("hold_cap", 1'b1, 1'b0, 1'b0);
        set_in(4'b0000, 1'b1);
        repeat (6) tick();
        chk_flags("hold_keep", 1'b1, 1'b0, 1'b0);
        chk_digit("hold_keep_d0", 2'b10, 7'h19);
        // Drop load for one cycle, raise again: capture at k+2
        load = 1'b0;
        tick();
        load = 1'b1;
        tick();
        tick();
        chk("rearm_k1_zero", 32'(zero), 32'h0);
        tick();
        chk("rearm_k2_zero", 32'(zero), 32'h1);
        chk_digit("rearm_d0", 2'b10, 7'h40);
        load = 1'b0;
        repeat (3) tick();

        // Reset while the capture pulse is high
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        set_in(4'b0100, 1'b1);
        load = 1'b1;
        tick();
        tick();
        #2;
        rst  = 1'b1;
        load = 1'b0;
        #1;
        chk("rstpulse_now_valid", 32'(valid), 32'h0);
        tick();
        chk_flags("rstpulse_k2", 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        repeat (4) tick();
        chk_flags("rstpulse_after", 1'b0, 1'b0, 1'b0);
        chk("rstpulse_seg", 32'(seg), 32'h7F);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
